mem_access: RTL and testbench

//  Memory-access stage directly downstream of the execute-stage ALU wrapper. Consumes the
//  ALU result, the write_reg/load_en/store_en controls and the store data. Performs the

---
 rtl/mem_access_pkg.sv | 35 +++
 rtl/mem_access.sv | 159 +++++++++++++++
 tb/tb_mem_access.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage.
//   state_e         : 2-bit FSM encoding (IDLE -> REQ -> WAIT -> DONE)
//   optype_e        : instruction classes decided at accept time
//   TIMEOUT_DEFAULT : default cycle budget for REQ+WAIT before aborting
//   classify()      : maps load/store enables and low address bits to an optype
package mem_access_pkg;

  localparam int TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    I_ALU   = 2'd0,  // no memory access, result passes through
    I_LOAD  = 2'd1,
    I_STORE = 2'd2,
    I_ERR   = 2'd3   // load+store both set, or misaligned word access
  } optype_e;

  function automatic optype_e classify(input logic load_en, input logic store_en,
                                       input logic [1:0] addr_lo);
    optype_e op;
    if (load_en && store_en)                       op = I_ERR;
    else if ((load_en || store_en) && addr_lo != 2'b00) op = I_ERR;
    else if (load_en)                              op = I_LOAD;
    else if (store_en)                             op = I_STORE;
    else                                           op = I_ALU;
    return op;
  endfunction

endpackage

// File: rtl/mem_access.sv
// Memory-access pipeline stage. Holds one instruction from execute, performs a
// word load/store on the data-memory bus, then presents a writeback bundle.
//   clk, rst                      : clock, synchronous active-high reset
//   in_valid/in_ready             : handshake from execute (ready only in IDLE)
//   in_result/in_store_data/in_rd : ALU result (address for LW/SW), store data, rd
//   in_write_reg/in_load_en/in_store_en : instruction controls
//   dmem_req_*                    : request channel (valid held until ready)
//   dmem_resp_valid/rdata         : one-cycle response pulse with load data
//   out_valid/out_ready           : writeback handshake
//   out_rd/out_write_reg/out_data/out_err : writeback bundle
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_result,
  input  logic [31:0] in_store_data,
  input  logic [4:0]  in_rd,
  input  logic        in_write_reg,
  input  logic        in_load_en,
  input  logic        in_store_en,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_req_we,
  output logic [31:0] dmem_req_addr,
  output logic [31:0] dmem_req_wdata,
  input  logic        dmem_resp_valid,
  input  logic [31:0] dmem_resp_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_rd,
  output logic        out_write_reg,
  output logic [31:0] out_data,
  output logic        out_err
);

  // Timeout fires while the counter sits on its last allowed value.
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT - 1);

  state_e      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic        we_reg, we_next;
  logic [4:0]  rd_reg, rd_next;
  logic [31:0] data_reg, data_next;
  logic        wr_reg, wr_next;
  logic        err_reg, err_next;
  logic        timeout_hit;

  assign timeout_hit = (cnt_reg == TIMEOUT_CNT);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    we_next    = we_reg;
    rd_next    = rd_reg;
    data_next  = data_reg;
    wr_next    = wr_reg;
    err_next   = err_reg;

    // Saturating count of cycles spent on the memory bus.
    if (state_reg == S_REQ || state_reg == S_WAIT) begin
      if (cnt_reg != 8'hFF) cnt_next = cnt_reg + 8'd1;
    end

    case (state_reg)
      S_IDLE: begin
        if (in_valid) begin
          addr_next  = in_result;
          wdata_next = in_store_data;
          we_next    = in_store_en;
          rd_next    = in_rd;
          data_next  = in_result;
          wr_next    = 1'b0;
          err_next   = 1'b0;
          cnt_next   = 8'd0;
          case (classify(in_load_en, in_store_en, in_result[1:0]))
            I_ALU: begin
              wr_next    = in_write_reg;
              state_next = S_DONE;
            end
            I_ERR: begin
              err_next   = 1'b1;
              state_next = S_DONE;
            end
            default: state_next = S_REQ;
          endcase
        end
      end
      S_REQ: begin
        // A response pulse here is not ours yet and is ignored.
        if (timeout_hit) begin
          err_next   = 1'b1;
          state_next = S_DONE;
        end else if (dmem_req_ready) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        // The response takes priority over a simultaneous timeout.
        if (dmem_resp_valid) begin
          data_next  = we_reg ? addr_reg : dmem_resp_rdata;
          wr_next    = ~we_reg;
          state_next = S_DONE;
        end else if (timeout_hit) begin
          err_next   = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 8'd0;
      addr_reg  <= 32'd0;
      wdata_reg <= 32'd0;
      we_reg    <= 1'b0;
      rd_reg    <= 5'd0;
      data_reg  <= 32'd0;
      wr_reg    <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      we_reg    <= we_next;
      rd_reg    <= rd_next;
      data_reg  <= data_next;
      wr_reg    <= wr_next;
      err_reg   <= err_next;
    end
  end

  assign in_ready       = (state_reg == S_IDLE);
  assign dmem_req_valid = (state_reg == S_REQ);
  assign dmem_req_we    = we_reg;
  assign dmem_req_addr  = addr_reg;
  assign dmem_req_wdata = wdata_reg;
  assign out_valid      = (state_reg == S_DONE);
  assign out_rd         = rd_reg;
  assign out_write_reg  = wr_reg;
  assign out_data       = data_reg;
  assign out_err        = err_reg;

endmodule

// File: tb/tb_mem_access.sv
// Testbench for mem_access: directed scenarios followed by randomized
// transactions, each checked against a transaction-level reference model that
// predicts completion cycle and writeback bundle from the memory timing.
module tb_mem_access;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_result, in_store_data;
  logic [4:0]  in_rd;
  logic        in_write_reg, in_load_en, in_store_en;
  logic        dmem_req_valid, dmem_req_ready, dmem_req_we;
  logic [31:0] dmem_req_addr, dmem_req_wdata;
  logic        dmem_resp_valid;
  logic [31:0] dmem_resp_rdata;
  logic        out_valid, out_ready;
  logic [4:0]  out_rd;
  logic        out_write_reg;
  logic [31:0] out_data;
  logic        out_err;

  int n_checks = 0;
  int n_errors = 0;
  int txn_id   = 0;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_store_data(in_store_data), .in_rd(in_rd),
    .in_write_reg(in_write_reg), .in_load_en(in_load_en), .in_store_en(in_store_en),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_we(dmem_req_we), .dmem_req_addr(dmem_req_addr),
    .dmem_req_wdata(dmem_req_wdata),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_rdata(dmem_resp_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd(out_rd), .out_write_reg(out_write_reg),
    .out_data(out_data), .out_err(out_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (txn %0d)", tag, obs, exp, txn_id);
    end
  endtask

  // Everything except in_ready must read zero right after reset.
  task automatic check_reset_outputs();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_flags", 32'({out_valid, dmem_req_valid, dmem_req_we, out_write_reg, out_err}), 32'd0);
    check("rst_addr", dmem_req_addr, 32'd0);
    check("rst_wdata", dmem_req_wdata, 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_rd", 32'(out_rd), 32'd0);
  endtask

  // One instruction through the stage. The memory accepts the request dr
  // cycles after REQ entry and responds dw cycles after entering WAIT.
  task automatic run_txn(input logic [4:0] rd, input logic wr, input logic ld,
                         input logic st, input logic [31:0] res, input logic [31:0] wd,
                         input logic [31:0] rdat, input int dr, input int dw,
                         input int hold);
    logic pre_err, is_mem, tmo, exp_err, exp_wr;
    logic [31:0] exp_data;
    int c, done_k, req_last;

    // Reference model: predicted outcome of this transaction.
    pre_err  = (ld && st) || ((ld || st) && res[1:0] != 2'b00);
    is_mem   = (ld || st) && !pre_err;
    c        = dr + 1 + dw;               // cycle index (from REQ entry) of the response
    tmo      = is_mem && (c > TO - 1);
    done_k   = !is_mem ? 0 : (tmo ? TO : c + 1);
    req_last = !is_mem ? -1 : ((dr < TO - 1) ? dr : TO - 1);
    exp_err  = pre_err || tmo;
    exp_wr   = exp_err ? 1'b0 : (!(ld || st) ? wr : ld);
    exp_data = ld ? rdat : res;

    @(posedge clk); #1;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_rd = rd; in_write_reg = wr; in_load_en = ld; in_store_en = st;
    in_result = res; in_store_data = wd; dmem_resp_rdata = rdat;
    @(posedge clk); #1;
    // Scramble the inputs so any leak from live inputs to outputs shows up.
    in_valid = 1'b0; in_result = $urandom; in_store_data = $urandom;
    in_rd = 5'($urandom); in_write_reg = 1'($urandom);
    in_load_en = 1'($urandom); in_store_en = 1'($urandom);

    for (int k = 0; k <= done_k; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      dmem_req_ready  = is_mem && (k == dr);
      dmem_resp_valid = is_mem && (k == c);
      check("req_valid", 32'(dmem_req_valid), 32'(k <= req_last));
      if (k <= req_last) begin
        check("req_addr", dmem_req_addr, res);
        check("req_we", 32'(dmem_req_we), 32'(st));
        if (st) check("req_wdata", dmem_req_wdata, wd);
      end
      check("out_valid", 32'(out_valid), 32'(k == done_k));
    end
    dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0;

    for (int h = 0; h <= hold; h++) begin
      if (h > 0) begin @(posedge clk); #1; end
      check("done_valid", 32'(out_valid), 32'd1);
      check("done_in_ready", 32'(in_ready), 32'd0);
      check("out_rd", 32'(out_rd), 32'(rd));
      check("out_write_reg", 32'(out_write_reg), 32'(exp_wr));
      check("out_err", 32'(out_err), 32'(exp_err));
      if (!exp_err) check("out_data", out_data, exp_data);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("back_idle_valid", 32'(out_valid), 32'd0);
    check("back_idle_ready", 32'(in_ready), 32'd1);
    $display("txn %0d: ld=%0d st=%0d res=0x%08h dr=%0d dw=%0d -> done@%0d err=%0d wr=%0d",
             txn_id, ld, st, res, dr, dw, done_k, exp_err, exp_wr);
    txn_id++;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_result = '0; in_store_data = '0; in_rd = '0;
    in_write_reg = 1'b0; in_load_en = 1'b0; in_store_en = 1'b0;
    dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; dmem_resp_rdata = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;

    // ADD passes its result straight through.
    run_txn(5'd5, 1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'h0, 0, 0, 0);
    // LW: ready after 2 cycles, response 3 cycles after that.
    run_txn(5'd7, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 2, 2, 0);
    // SW with a slow ready, then WB stalls the bundle for 4 cycles.
    run_txn(5'd3, 1'b0, 1'b0, 1'b1, 32'h0000_0204, 32'h1234_5678, 32'h0, 3, 0, 4);
    // Misaligned LW never touches memory.
    run_txn(5'd9, 1'b1, 1'b1, 1'b0, 32'h0000_0102, 32'h0, 32'h0, 0, 0, 0);
    // Load and store both set.
    run_txn(5'd4, 1'b1, 1'b1, 1'b1, 32'h0000_0040, 32'h0, 32'h0, 0, 0, 0);
    // Response arriving exactly on the timeout cycle wins.
    run_txn(5'd2, 1'b1, 1'b1, 1'b0, 32'h0000_0080, 32'h0, 32'hCAFE_F00D, 1, 5, 0);
    // Memory never responds: timeout, then a late response in IDLE is ignored.
    run_txn(5'd6, 1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 32'h0, 1, 100, 0);
    dmem_resp_valid = 1'b1;
    @(posedge clk); #1;
    dmem_resp_valid = 1'b0;
    check("late_resp_valid", 32'(out_valid), 32'd0);
    check("late_resp_ready", 32'(in_ready), 32'd1);

    // Reset while waiting for a load response.
    @(posedge clk); #1;
    in_valid = 1'b1; in_load_en = 1'b1; in_store_en = 1'b0; in_result = 32'h0000_0500;
    in_rd = 5'd11; in_write_reg = 1'b1; in_store_data = 32'hFFFF_0000;
    @(posedge clk); #1;
    in_valid = 1'b0; dmem_req_ready = 1'b1;
    check("pre_rst_req", 32'(dmem_req_valid), 32'd1);
    @(posedge clk); #1;
    dmem_req_ready = 1'b0;
    check("pre_rst_wait", 32'({dmem_req_valid, in_ready, out_valid}), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs();
    dmem_resp_valid = 1'b1; dmem_resp_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    dmem_resp_valid = 1'b0;
    check("post_rst_resp", 32'(out_valid), 32'd0);
    run_txn(5'd12, 1'b1, 1'b0, 1'b0, 32'h0000_0077, 32'h0, 32'h0, 0, 0, 0);

    // Randomized mix of ALU ops, loads, stores, malformed ops and slow memory.
    for (int i = 0; i < 40; i++) begin
      int kind, dr, dw, hold;
      logic ld, st;
      logic [31:0] res;
      kind = $urandom_range(0, 9);
      ld = (kind >= 3 && kind <= 5) || kind >= 8;
      st = (kind == 6 || kind == 7 || kind == 9);
      res = $urandom;
      if (kind >= 3 && kind <= 7) res[1:0] = 2'b00;
      if (kind == 8 && res[1:0] == 2'b00) res[0] = 1'b1;
      if ($urandom_range(0, 5) == 0) begin
        dr = $urandom_range(0, 9); dw = $urandom_range(0, 9);
      end else begin
        dr = $urandom_range(0, 3); dw = $urandom_range(0, 3);
      end
      hold = $urandom_range(0, 2);
      run_txn(5'($urandom), 1'($urandom), ld, st, res, $urandom, $urandom, dr, dw, hold);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
